elevator_scheduler: RTL and testbench

- Request scheduler sitting in front of the elevator car controller.
- Latches hall and cab calls into a pending-request vector and picks the next destination using LOOK ordering: keep direction while requests lie ahead, else reverse.
- Drives the car's destination floor, then sequences door-open dwell on arrival.
- Enforces safety: door opens only while the car is at rest at the serviced floor, never during travel or emergency.

---
 rtl/elevator_pkg.sv | 17 +
 rtl/elevator_next_floor_sel.sv | 66 ++++++
 rtl/elevator_scheduler.sv | 143 ++++++++++++++
 tb/tb_elevator_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared types and default sizing for the elevator scheduler.
// Holds the scheduler FSM state enum and the default parameter constants.
package elevator_pkg;

   localparam int NUM_FLOORS  = 10;
   localparam int FLOOR_W     = 4;
   localparam int DOOR_CYCLES = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DISPATCH  = 3'd1,
      TRAVEL    = 3'd2,
      DOOR_OPEN = 3'd3,
      HALT      = 3'd4
   } sched_state_t;

endpackage

// File: rtl/elevator_next_floor_sel.sv
// elevator_next_floor_sel: combinational LOOK selector.
// Ports: i_pending, i_cur_floor, i_dir_up in; o_found, o_next_floor, o_next_dir_up out.
module elevator_next_floor_sel
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
   parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
   input  logic [NUM_FLOORS-1:0] i_pending,
   input  logic [FLOOR_W-1:0]    i_cur_floor,
   input  logic                  i_dir_up,
   output logic                  o_found,
   output logic [FLOOR_W-1:0]    o_next_floor,
   output logic                  o_next_dir_up
);

   logic               w_has_above;
   logic               w_has_below;
   logic [FLOOR_W-1:0] w_above;
   logic [FLOOR_W-1:0] w_below;

   // Descending scan leaves the lowest index above; ascending scan leaves
   // the highest index below.
   always_comb begin
      w_has_above = 1'b0;
      w_has_below = 1'b0;
      w_above     = '0;
      w_below     = '0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (i_pending[i] && (i > int'(i_cur_floor))) begin
            w_has_above = 1'b1;
            w_above     = FLOOR_W'(i);
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (i_pending[i] && (i < int'(i_cur_floor))) begin
            w_has_below = 1'b1;
            w_below     = FLOOR_W'(i);
         end
      end
   end

   always_comb begin
      o_found       = w_has_above | w_has_below;
      o_next_floor  = i_cur_floor;
      o_next_dir_up = i_dir_up;
      if (i_dir_up) begin
         if (w_has_above) begin
            o_next_floor  = w_above;
            o_next_dir_up = 1'b1;
         end else if (w_has_below) begin
            o_next_floor  = w_below;
            o_next_dir_up = 1'b0;
         end
      end else begin
         if (w_has_below) begin
            o_next_floor  = w_below;
            o_next_dir_up = 1'b0;
         end else if (w_has_above) begin
            o_next_floor  = w_above;
            o_next_dir_up = 1'b1;
         end
      end
   end

endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: latches hall/cab calls, issues LOOK-ordered destinations,
// sequences door dwell and emergency halt.
// Ports: clk, rst (async, active high); i_hall_call, i_cab_call, i_cur_floor,
//   i_car_idle, i_emergency, i_emer_resolve in; o_dest_floor, o_dest_valid,
//   o_dir_up, o_door_open, o_pending, o_state out.
// Option: ELEV_SCHED_RETARGET_EN enables mid-travel retarget to a nearer call.
module elevator_scheduler #(
   parameter int NUM_FLOORS  = elevator_pkg::NUM_FLOORS,
   parameter int FLOOR_W     = elevator_pkg::FLOOR_W,
   parameter int DOOR_CYCLES = elevator_pkg::DOOR_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] i_hall_call,
   input  logic [NUM_FLOORS-1:0] i_cab_call,
   input  logic [FLOOR_W-1:0]    i_cur_floor,
   input  logic                  i_car_idle,
   input  logic                  i_emergency,
   input  logic                  i_emer_resolve,
   output logic [FLOOR_W-1:0]    o_dest_floor,
   output logic                  o_dest_valid,
   output logic                  o_dir_up,
   output logic                  o_door_open,
   output logic [NUM_FLOORS-1:0] o_pending,
   output logic [2:0]            o_state
);

   import elevator_pkg::*;

   localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

   sched_state_t          r_state;
   sched_state_t          w_next_state;
   logic [NUM_FLOORS-1:0] r_pending;
   logic [FLOOR_W-1:0]    r_dest;
   logic                  r_dir_up;
   logic [CNT_W-1:0]      r_cnt;

   logic [NUM_FLOORS-1:0] w_cur_onehot;
   logic [NUM_FLOORS-1:0] w_clr;
   logic                  w_cur_hit;
   logic                  w_sel_found;
   logic [FLOOR_W-1:0]    w_sel_floor;
   logic                  w_sel_dir;
   logic                  w_arrived;
   logic                  w_retarget;

   elevator_next_floor_sel #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_sel (
      .i_pending     (r_pending),
      .i_cur_floor   (i_cur_floor),
      .i_dir_up      (r_dir_up),
      .o_found       (w_sel_found),
      .o_next_floor  (w_sel_floor),
      .o_next_dir_up (w_sel_dir)
   );

   assign w_cur_onehot = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << i_cur_floor;
   assign w_cur_hit    = |(r_pending & w_cur_onehot);
   assign w_arrived    = (i_cur_floor == r_dest) && i_car_idle;

`ifdef ELEV_SCHED_RETARGET_EN
   // The selector already returns the nearest call ahead when it keeps the
   // sweep direction; retarget only if that call is short of the destination.
   assign w_retarget = w_sel_found && (w_sel_dir == r_dir_up) &&
                       (r_dir_up ? (w_sel_floor < r_dest)
                                 : (w_sel_floor > r_dest));
`else
   assign w_retarget = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      if (i_emergency) begin
         w_next_state = HALT;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_cur_hit && i_car_idle) w_next_state = DOOR_OPEN;
               else if (w_sel_found)        w_next_state = DISPATCH;
            end
            DISPATCH: begin
               // Car may have moved onto the only pending floor meanwhile.
               w_next_state = w_sel_found ? TRAVEL : IDLE;
            end
            TRAVEL: begin
               if (w_arrived) w_next_state = DOOR_OPEN;
            end
            DOOR_OPEN: begin
               if (!i_car_idle)       w_next_state = HALT;
               else if (r_cnt == '0)  w_next_state = IDLE;
            end
            HALT: begin
               if (i_emer_resolve) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
         endcase
      end
   end

   // The serviced floor's call is cleared on entry and throughout the dwell,
   // so a re-press at that floor is absorbed.
   assign w_clr = ((w_next_state == DOOR_OPEN) || (r_state == DOOR_OPEN))
                ? w_cur_onehot : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_dest    <= '0;
         r_dir_up  <= 1'b1;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_next_state;
         r_pending <= (r_pending | i_hall_call | i_cab_call) & ~w_clr;

         if (r_state == DISPATCH && w_next_state == TRAVEL) begin
            r_dest   <= w_sel_floor;
            r_dir_up <= w_sel_dir;
         end else if (r_state == TRAVEL && w_next_state == TRAVEL &&
                      w_retarget) begin
            r_dest <= w_sel_floor;
         end

         if (w_next_state == DOOR_OPEN && r_state != DOOR_OPEN)
            r_cnt <= CNT_W'(DOOR_CYCLES - 1);
         else if (w_next_state == DOOR_OPEN)
            r_cnt <= r_cnt - 1'b1;
         else
            r_cnt <= '0;
      end
   end

   assign o_dest_floor = r_dest;
   assign o_dest_valid = (r_state == TRAVEL);
   assign o_dir_up     = r_dir_up;
   assign o_door_open  = (r_state == DOOR_OPEN) && i_car_idle;
   assign o_pending    = r_pending;
   assign o_state      = r_state;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed scenarios plus randomized traffic against a
// behavioural model of the scheduling rules, with a simple car model.
module tb_elevator_scheduler;

   localparam int NF = 10;
   localparam int FW = 4;
   localparam int DC = 4;
   localparam int CAR_PERIOD = 3;
`ifdef ELEV_SCHED_RETARGET_EN
   localparam bit RETARGET = 1'b1;
`else
   localparam bit RETARGET = 1'b0;
`endif

   localparam int M_IDLE = 0;
   localparam int M_DISP = 1;
   localparam int M_TRAV = 2;
   localparam int M_DOOR = 3;
   localparam int M_HALT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NF-1:0] i_hall_call;
   logic [NF-1:0] i_cab_call;
   logic [FW-1:0] i_cur_floor;
   logic          i_car_idle;
   logic          i_emergency;
   logic          i_emer_resolve;
   logic [FW-1:0] o_dest_floor;
   logic          o_dest_valid;
   logic          o_dir_up;
   logic          o_door_open;
   logic [NF-1:0] o_pending;
   logic [2:0]    o_state;

   elevator_scheduler #(
      .NUM_FLOORS  (NF),
      .FLOOR_W     (FW),
      .DOOR_CYCLES (DC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_hall_call    (i_hall_call),
      .i_cab_call     (i_cab_call),
      .i_cur_floor    (i_cur_floor),
      .i_car_idle     (i_car_idle),
      .i_emergency    (i_emergency),
      .i_emer_resolve (i_emer_resolve),
      .o_dest_floor   (o_dest_floor),
      .o_dest_valid   (o_dest_valid),
      .o_dir_up       (o_dir_up),
      .o_door_open    (o_door_open),
      .o_pending      (o_pending),
      .o_state        (o_state)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   int            m_st;
   logic [NF-1:0] m_pend;
   int            m_dest;
   bit            m_dir;
   int            m_cnt;

   int car_floor;
   bit car_idle;
   int move_cnt;
   int stops[$];
   bit prev_door;
   int door_hi;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void m_select(input logic [NF-1:0] p, input int cur,
                                    input bit dir, output bit found,
                                    output int nf, output bit nd);
      int above = -1;
      int below = -1;
      for (int f = cur + 1; f < NF; f++)
         if (p[f] && above < 0) above = f;
      for (int f = cur - 1; f >= 0; f--)
         if (p[f] && below < 0) below = f;
      found = (above >= 0) || (below >= 0);
      nf = cur;
      nd = dir;
      if (dir) begin
         if (above >= 0)      begin nf = above; nd = 1'b1; end
         else if (below >= 0) begin nf = below; nd = 1'b0; end
      end else begin
         if (below >= 0)      begin nf = below; nd = 1'b0; end
         else if (above >= 0) begin nf = above; nd = 1'b1; end
      end
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_pend = '0; m_dest = 0; m_dir = 1'b1; m_cnt = 0;
   endtask

   task automatic model_step();
      int cur = int'(i_cur_floor);
      bit found;
      int nf;
      bit nd;
      int nst;
      int stp;
      bit done;
      logic [NF-1:0] clr;
      m_select(m_pend, cur, m_dir, found, nf, nd);
      nst = m_st;
      if (i_emergency) nst = M_HALT;
      else begin
         case (m_st)
            M_IDLE: if (m_pend[cur] && i_car_idle) nst = M_DOOR;
                    else if (found) nst = M_DISP;
            M_DISP: if (found) begin
                       nst = M_TRAV; m_dest = nf; m_dir = nd;
                    end else nst = M_IDLE;
            M_TRAV: if (cur == m_dest && i_car_idle) nst = M_DOOR;
                    else if (RETARGET) begin
                       stp = m_dir ? 1 : -1;
                       done = 1'b0;
                       for (int f = cur + stp; f >= 0 && f < NF && f != m_dest;
                            f += stp)
                          if (!done && m_pend[f]) begin m_dest = f; done = 1'b1; end
                    end
            M_DOOR: if (!i_car_idle) nst = M_HALT;
                    else if (m_cnt == 0) nst = M_IDLE;
                    else m_cnt--;
            M_HALT: if (i_emer_resolve) nst = M_IDLE;
            default: nst = M_IDLE;
         endcase
      end
      if (nst == M_DOOR && m_st != M_DOOR) m_cnt = DC - 1;
      else if (nst != M_DOOR) m_cnt = 0;
      clr = (nst == M_DOOR || m_st == M_DOOR) ? (NF'(1) << cur) : '0;
      m_pend = (m_pend | i_hall_call | i_cab_call) & ~clr;
      m_st = nst;
   endtask

   task automatic compare_all();
      check("state",   o_state,      m_st);
      check("dest",    o_dest_floor, m_dest);
      check("valid",   o_dest_valid, m_st == M_TRAV);
      check("dir",     o_dir_up,     m_dir);
      check("door",    o_door_open,  m_st == M_DOOR && i_car_idle);
      check("pending", o_pending,    m_pend);
   endtask

   task automatic car_move();
      int d = int'(o_dest_floor);
      if (o_dest_valid && car_floor != d) begin
         car_idle = 1'b0;
         move_cnt++;
         if (move_cnt >= CAR_PERIOD) begin
            move_cnt = 0;
            car_floor += (d > car_floor) ? 1 : -1;
            if (car_floor == d) car_idle = 1'b1;
         end
      end else begin
         car_idle = 1'b1;
         move_cnt = 0;
      end
      i_cur_floor = FW'(car_floor);
      i_car_idle  = car_idle;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      if (o_door_open && !prev_door) stops.push_back(int'(i_cur_floor));
      if (o_door_open) door_hi++;
      prev_door   = o_door_open;
      i_hall_call = '0;
      i_cab_call  = '0;
      car_move();
   endtask

   task automatic do_reset(input int floor);
      rst = 1'b1;
      i_hall_call = '0; i_cab_call = '0;
      i_emergency = 1'b0; i_emer_resolve = 1'b0;
      car_floor = floor; car_idle = 1'b1; move_cnt = 0;
      i_cur_floor = FW'(floor); i_car_idle = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      prev_door = 1'b0;
      stops.delete();
      door_hi = 0;
   endtask

   task automatic run_quiet(input string tag, input int budget);
      int k = 0;
      while (!(m_st == M_IDLE && m_pend == '0) && k < budget) begin
         step();
         k++;
      end
      check(tag, (m_st == M_IDLE && m_pend == '0), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state
      do_reset(0);
      check("rst_state", o_state, 0);
      check("rst_dest",  o_dest_floor, 0);
      check("rst_valid", o_dest_valid, 0);
      check("rst_dir",   o_dir_up, 1);
      check("rst_door",  o_door_open, 0);
      check("rst_pend",  o_pending, 0);

      // Single cab call from floor 0 to 3
      i_cab_call[3] = 1'b1;
      step();
      check("t1_pend3", o_pending[3], 1);
      step();
      step();
      check("t1_dest",  o_dest_floor, 3);
      check("t1_valid", o_dest_valid, 1);
      check("t1_dir",   o_dir_up, 1);
      run_quiet("t1_quiet", 80);
      check("t1_nstop", stops.size(), 1);
      if (stops.size() > 0) check("t1_stop", stops[0], 3);
      check("t1_dwell", door_hi, DC);

      // LOOK order: 5 -> 8, then calls at 2 and 9
      do_reset(5);
      i_cab_call[8] = 1'b1;
      step(); step(); step(); step();
      i_hall_call[2] = 1'b1;
      i_hall_call[9] = 1'b1;
      run_quiet("t2_quiet", 200);
      check("t2_nstop", stops.size(), 3);
      if (stops.size() == 3) begin
         check("t2_stop0", stops[0], 8);
         check("t2_stop1", stops[1], 9);
         check("t2_stop2", stops[2], 2);
      end

      // Call at current floor opens immediately; re-press absorbed
      do_reset(4);
      i_hall_call[4] = 1'b1;
      step();
      step();
      check("t3_state", o_state, M_DOOR);
      check("t3_door",  o_door_open, 1);
      i_hall_call[4] = 1'b1;
      step();
      check("t3_pend4", o_pending[4], 0);
      run_quiet("t3_quiet", 40);
      check("t3_valid_never", stops.size(), 1);

      // Emergency during travel to 7
      do_reset(0);
      i_cab_call[7] = 1'b1;
      step(); step(); step();
      check("t4_valid", o_dest_valid, 1);
      step(); step(); step(); step();
      i_emergency = 1'b1;
      step();
      check("t4_halt",  o_state, M_HALT);
      check("t4_valid0", o_dest_valid, 0);
      check("t4_door0", o_door_open, 0);
      check("t4_pend7", o_pending[7], 1);
      i_emer_resolve = 1'b1;
      step();
      check("t4_both", o_state, M_HALT);
      i_emergency = 1'b0;
      step();
      check("t4_resolved", o_state, M_IDLE);
      i_emer_resolve = 1'b0;
      run_quiet("t4_quiet", 120);
      check("t4_laststop", (stops.size() > 0) ? stops[stops.size()-1] : -1, 7);

      // Asynchronous reset in the middle of a dwell
      do_reset(0);
      i_cab_call[0] = 1'b1;
      step(); step();
      i_hall_call[4] = 1'b1;
      i_cab_call[7] = 1'b1;
      step();
      check("t5_state", o_state, M_DOOR);
      check("t5_pend",  o_pending, 10'b0010010000);
      #2;
      rst = 1'b1;
      #1;
      check("t5_rst_state", o_state, 0);
      check("t5_rst_dest",  o_dest_floor, 0);
      check("t5_rst_valid", o_dest_valid, 0);
      check("t5_rst_dir",   o_dir_up, 1);
      check("t5_rst_door",  o_door_open, 0);
      check("t5_rst_pend",  o_pending, 0);
      do_reset(0);

      // Retarget on the way: 1 -> 8 with a call at 4 while at 2
      do_reset(1);
      i_cab_call[8] = 1'b1;
      for (int k = 0; k < 30 && car_floor != 2; k++) step();
      check("t6_at2", car_floor, 2);
      i_hall_call[4] = 1'b1;
      step();
      step();
      check("t6_dest", o_dest_floor, RETARGET ? 4 : 8);
      run_quiet("t6_quiet", 120);
      if (stops.size() > 0) check("t6_first", stops[0], RETARGET ? 4 : 8);

      // Randomized traffic
      do_reset(0);
      for (int c = 0; c < 3000; c++) begin
         int em_left;
         if (c == 0) em_left = 0;
         if ($urandom % 5 == 0) begin
            if ($urandom % 2 == 0) i_hall_call[$urandom % NF] = 1'b1;
            else                   i_cab_call[$urandom % NF]  = 1'b1;
         end
         if (em_left > 0) begin
            em_left--;
            i_emergency = 1'b1;
         end else if ($urandom % 120 == 0) begin
            em_left = int'($urandom_range(0, 3));
            i_emergency = 1'b1;
         end else begin
            i_emergency = 1'b0;
         end
         i_emer_resolve = ($urandom % 5 == 0);
         if (o_door_open && ($urandom % 25 == 0)) i_car_idle = 1'b0;
         step();
      end
      i_emergency = 1'b0;
      i_emer_resolve = 1'b1;
      step();
      i_emer_resolve = 1'b0;
      run_quiet("rand_quiet", 1500);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
